// File: rtl/dma_addr_counter_if.sv
// -----------------------------------------------------------------------------
// dma_addr_counter_if
// Groups the DMA address counter's control and status signals into a bundle.
//   master : the controlling side (drives loads, start/step, mode bits, stat_rd)
//   slave  : the address counter itself (drives addr_out, adstb, busy, tc,
//            tc_status)
// Parameters: NCH channels (channel selects are clog2(NCH) bits), AW address /
// word-count width.
// -----------------------------------------------------------------------------
interface dma_addr_counter_if #(
  parameter int NCH = 4,
  parameter int AW  = 16
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic           load_en;
  logic [CW-1:0]  load_ch;
  logic [AW-1:0]  load_addr;
  logic [AW-1:0]  load_word;
  logic           start;
  logic [CW-1:0]  srv_ch;
  logic           step;
  logic           end_req;
  logic [NCH-1:0] addr_dec;
  logic [NCH-1:0] autoinit;
  logic           stat_rd;
  logic [AW-1:0]  addr_out;
  logic           adstb;
  logic           busy;
  logic           tc;
  logic [NCH-1:0] tc_status;

  modport master (
    output load_en, load_ch, load_addr, load_word, start, srv_ch, step,
           end_req, addr_dec, autoinit, stat_rd,
    input  addr_out, adstb, busy, tc, tc_status
  );

  modport slave (
    input  load_en, load_ch, load_addr, load_word, start, srv_ch, step,
           end_req, addr_dec, autoinit, stat_rd,
    output addr_out, adstb, busy, tc, tc_status
  );
endinterface

// File: rtl/dma_addr_counter.sv
// -----------------------------------------------------------------------------
// dma_addr_counter
// Per-channel DMA address / word counters with a small service FSM
// (IDLE -> ADDR -> XFER). ADDR presents the full address with a one-cycle
// adstb; XFER counts steps, re-entering ADDR only when the upper address byte
// changes. A step that finds the word count at zero is the terminal count.
//
// Ports:
//   CLK         single clock, all state changes on its rising edge
//   RESET       asynchronous active-high reset
//   masterClear synchronous clear with the same effect as RESET
//   bus         dma_addr_counter_if.slave (loads, start/step/end_req, mode
//               bits, stat_rd in; addr_out, adstb, busy, tc, tc_status out)
//
// Build option: define DMA_AUTOINIT_EN to reload a channel's current address
// and word from its base registers on terminal count when autoinit[ch] = 1.
// -----------------------------------------------------------------------------
module dma_addr_counter #(
  parameter int NCH = 4,
  parameter int AW  = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  masterClear,
  dma_addr_counter_if.slave     bus
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, ADDR, XFER} state_t;

  state_t                   state;
  logic [CW-1:0]            act_ch;
  logic [NCH-1:0][AW-1:0]   base_addr;
  logic [NCH-1:0][AW-1:0]   base_word;
  logic [NCH-1:0][AW-1:0]   cur_addr;
  logic [NCH-1:0][AW-1:0]   cur_word;
  logic [AW-1:0]            addr_q;
  logic                     adstb_q;
  logic                     busy_q;
  logic                     tc_q;
  logic [NCH-1:0]           tc_status_q;

  // Next-step values of the active channel.
  logic [AW-1:0]  cur_a;
  logic [AW-1:0]  cur_w;
  logic [AW-1:0]  nxt_a;
  logic [AW-1:0]  nxt_w;
  logic           step_ok;
  logic           is_tc;
  logic           hi_change;
  logic [NCH-1:0] tc_set;

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    tc_set    = '0;
    cur_a     = cur_addr[act_ch];
    cur_w     = cur_word[act_ch];
    nxt_a     = bus.addr_dec[act_ch] ? cur_a - AW'(1) : cur_a + AW'(1);
    nxt_w     = cur_w - AW'(1);
    step_ok   = (state == XFER) && bus.step;
    is_tc     = step_ok && (cur_w == '0);
    hi_change = (nxt_a[AW-1:8] != cur_a[AW-1:8]);
    if (is_tc) tc_set[act_ch] = 1'b1;
  end

  // NOTE: the counter arrays are state the outside world can observe after a
  // clear, so they are reset like any other register rather than left as
  // uninitialised storage.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      act_ch      <= '0;
      base_addr   <= '0;
      base_word   <= '0;
      cur_addr    <= '0;
      cur_word    <= '0;
      addr_q      <= '0;
      adstb_q     <= 1'b0;
      busy_q      <= 1'b0;
      tc_q        <= 1'b0;
      tc_status_q <= '0;
    end else if (masterClear) begin
      state       <= IDLE;
      act_ch      <= '0;
      base_addr   <= '0;
      base_word   <= '0;
      cur_addr    <= '0;
      cur_word    <= '0;
      addr_q      <= '0;
      adstb_q     <= 1'b0;
      busy_q      <= 1'b0;
      tc_q        <= 1'b0;
      tc_status_q <= '0;
    end else begin
      tc_q <= 1'b0;

      // Loads to the channel currently being serviced are dropped; since a
      // step only occurs while busy, a load and a step never hit one channel.
      for (int i = 0; i < NCH; i++) begin
        if (bus.load_en && (bus.load_ch == CW'(i)) &&
            !(busy_q && (act_ch == CW'(i)))) begin
          base_addr[i] <= bus.load_addr;
          base_word[i] <= bus.load_word;
          cur_addr[i]  <= bus.load_addr;
          cur_word[i]  <= bus.load_word;
        end
      end

      if (step_ok) begin
        cur_addr[act_ch] <= nxt_a;
        cur_word[act_ch] <= nxt_w;
`ifdef DMA_AUTOINIT_EN
        if (is_tc && bus.autoinit[act_ch]) begin
          cur_addr[act_ch] <= base_addr[act_ch];
          cur_word[act_ch] <= base_word[act_ch];
        end
`endif
      end

      // A TC set on the same edge as a status read survives the clear.
      tc_status_q <= (tc_status_q & ~{NCH{bus.stat_rd}}) | tc_set;

      case (state)
        IDLE: begin
          if (bus.start) begin
            act_ch  <= bus.srv_ch;
            addr_q  <= cur_addr[bus.srv_ch];
            adstb_q <= 1'b1;
            busy_q  <= 1'b1;
            state   <= ADDR;
          end
        end
        ADDR: begin
          adstb_q <= 1'b0;
          state   <= XFER;
        end
        XFER: begin
          if (bus.step) begin
            if (is_tc) begin
              tc_q   <= 1'b1;
              busy_q <= 1'b0;
              state  <= IDLE;
            end else if (bus.end_req) begin
              busy_q <= 1'b0;
              state  <= IDLE;
            end else begin
              addr_q <= nxt_a;
              if (hi_change) begin
                adstb_q <= 1'b1;
                state   <= ADDR;
              end
            end
          end
        end
        default: begin
          adstb_q <= 1'b0;
          busy_q  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

`ifndef DMA_AUTOINIT_EN
  // Without auto-initialise the base registers and autoinit bits have no reader.
  logic unused_autoinit;
  assign unused_autoinit = ^{bus.autoinit, base_addr, base_word};
`endif

  assign bus.addr_out  = addr_q;
  assign bus.adstb     = adstb_q;
  assign bus.busy      = busy_q;
  assign bus.tc        = tc_q;
  assign bus.tc_status = tc_status_q;
endmodule

// File: tb/tb_dma_addr_counter.sv
// -----------------------------------------------------------------------------
// tb_dma_addr_counter
// Table-driven bench for dma_addr_counter: each record holds one cycle of
// inputs plus the outputs expected after the following rising edge. Expected
// records go into a queue as stimulus is driven and are popped and compared
// once the DUT has clocked. Reset behaviour is covered by hand-written
// sequences around the table.
// -----------------------------------------------------------------------------
module tb_dma_addr_counter;
`ifdef DMA_AUTOINIT_EN
  localparam bit AI = 1'b1;
`else
  localparam bit AI = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  logic masterClear = 1'b0;

  dma_addr_counter_if #(.NCH(4), .AW(16)) bus ();

  dma_addr_counter #(.NCH(4), .AW(16)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .masterClear (masterClear),
    .bus         (bus.slave)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit        st;
    bit [1:0]  ch;
    bit        sp;
    bit        er;
    bit        sr;
    bit        mc;
    bit        ld;
    bit [1:0]  ldch;
    bit [15:0] lda;
    bit [15:0] ldw;
    bit [15:0] ea;
    bit        eadstb;
    bit        ebusy;
    bit        etc;
    bit [3:0]  etcs;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];
  vec_t exp_q[$];
  int   vec_idx = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit st, bit [1:0] ch, bit sp, bit er, bit sr,
                              bit [15:0] ea, bit eadstb, bit ebusy, bit etc,
                              bit [3:0] etcs, bit ld = 1'b0, bit [1:0] ldch = 2'd0,
                              bit [15:0] lda = 16'h0, bit [15:0] ldw = 16'h0,
                              bit mc = 1'b0);
    vec_t v;
    v.st = st; v.ch = ch; v.sp = sp; v.er = er; v.sr = sr; v.mc = mc;
    v.ld = ld; v.ldch = ldch; v.lda = lda; v.ldw = ldw;
    v.ea = ea; v.eadstb = eadstb; v.ebusy = ebusy; v.etc = etc; v.etcs = etcs;
    return v;
  endfunction

  // Idle-cycle load: outputs simply hold.
  function automatic vec_t mkld(bit [1:0] ch, bit [15:0] a, bit [15:0] w,
                                bit [15:0] ea, bit [3:0] etcs);
    return mk(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, ea, 1'b0, 1'b0, 1'b0, etcs,
              1'b1, ch, a, w);
  endfunction

  task automatic compare_front();
    vec_t e;
    string n;
    e = exp_q.pop_front();
    n = $sformatf("v%0d", vec_idx);
    check({n, ".addr_out"},  {16'h0, bus.addr_out}, {16'h0, e.ea});
    check({n, ".adstb"},     {31'h0, bus.adstb},    {31'h0, e.eadstb});
    check({n, ".busy"},      {31'h0, bus.busy},     {31'h0, e.ebusy});
    check({n, ".tc"},        {31'h0, bus.tc},       {31'h0, e.etc});
    check({n, ".tc_status"}, {28'h0, bus.tc_status}, {28'h0, e.etcs});
    vec_idx++;
  endtask

  task automatic apply(input vec_t v);
    bus.start     = v.st;
    bus.srv_ch    = v.ch;
    bus.step      = v.sp;
    bus.end_req   = v.er;
    bus.stat_rd   = v.sr;
    bus.load_en   = v.ld;
    bus.load_ch   = v.ldch;
    bus.load_addr = v.lda;
    bus.load_word = v.ldw;
    masterClear   = v.mc;
    exp_q.push_back(v);
    @(posedge CLK);
    #1;
    compare_front();
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0; bus.srv_ch = '0; bus.step = 1'b0; bus.end_req = 1'b0;
    bus.stat_rd = 1'b0; bus.load_en = 1'b0; bus.load_ch = '0;
    bus.load_addr = '0; bus.load_word = '0; masterClear = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, ".addr_out"},  {16'h0, bus.addr_out}, 32'h0);
    check({tag, ".adstb"},     {31'h0, bus.adstb},    32'h0);
    check({tag, ".busy"},      {31'h0, bus.busy},     32'h0);
    check({tag, ".tc"},        {31'h0, bus.tc},       32'h0);
    check({tag, ".tc_status"}, {28'h0, bus.tc_status}, 32'h0);
  endtask

  localparam bit [15:0] RE2 = AI ? 16'h0000 : 16'hFFFF;

  initial begin
    idle_inputs();
    bus.addr_dec = 4'b0100;
    bus.autoinit = 4'b0100;

    // Table: {st, ch, sp, er, sr, exp addr, adstb, busy, tc, tc_status, [load...]}
    // ch0 incrementing, 3 steps of a word=2 transfer; step in ADDR ignored.
    vecs.push_back(mkld(2'd0, 16'h1000, 16'h0002, 16'h0000, 4'h0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 16'h1000, 1, 1, 0, 4'h0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 16'h1000, 0, 1, 0, 4'h0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 16'h1001, 0, 1, 0, 4'h0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 16'h1002, 0, 1, 0, 4'h0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 16'h1002, 0, 0, 1, 4'h1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 16'h1002, 0, 0, 0, 4'h1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 16'h1002, 0, 0, 0, 4'h0));
    // ch1 crosses a 256-byte page: re-strobe at 0x1100, none at 0x1101.
    vecs.push_back(mkld(2'd1, 16'h10FF, 16'h0005, 16'h1002, 4'h0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 16'h10FF, 1, 1, 0, 4'h0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 16'h10FF, 0, 1, 0, 4'h0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 16'h1100, 1, 1, 0, 4'h0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 16'h1100, 0, 1, 0, 4'h0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 16'h1101, 0, 1, 0, 4'h0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 16'h1101, 0, 0, 0, 4'h0));
    // ch2 decrementing from 0 with word 0: immediate TC, address wraps.
    vecs.push_back(mkld(2'd2, 16'h0000, 16'h0000, 16'h1101, 4'h0));
    vecs.push_back(mk(1, 2, 0, 0, 0, 16'h0000, 1, 1, 0, 4'h0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 0, 1, 0, 4'h0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 16'h0000, 0, 0, 1, 4'h4));
    vecs.push_back(mk(1, 2, 0, 0, 0, RE2, 1, 1, 0, 4'h4));
    vecs.push_back(mk(0, 0, 0, 0, 0, RE2, 0, 1, 0, 4'h4));
    vecs.push_back(mk(0, 0, 1, 1, 0, RE2, 0, 0, AI, 4'h4));
    // ch3 TC coincident with a status read: only bit 3 survives.
    vecs.push_back(mkld(2'd3, 16'h2000, 16'h0000, RE2, 4'h4));
    vecs.push_back(mk(1, 3, 0, 0, 0, 16'h2000, 1, 1, 0, 4'h4));
    vecs.push_back(mk(0, 0, 0, 0, 0, 16'h2000, 0, 1, 0, 4'h4));
    vecs.push_back(mk(0, 0, 1, 0, 1, 16'h2000, 0, 0, 1, 4'h8));
    // ch0 busy: its load is dropped, ch1 load lands; start while busy ignored.
    vecs.push_back(mkld(2'd0, 16'h3000, 16'h0003, 16'h2000, 4'h8));
    vecs.push_back(mk(1, 0, 0, 0, 0, 16'h3000, 1, 1, 0, 4'h8));
    vecs.push_back(mk(0, 0, 0, 0, 0, 16'h3000, 0, 1, 0, 4'h8, 1, 2'd0, 16'h4444, 16'h0000));
    vecs.push_back(mk(0, 0, 0, 0, 0, 16'h3000, 0, 1, 0, 4'h8, 1, 2'd1, 16'h5555, 16'h0001));
    vecs.push_back(mk(1, 2, 1, 0, 0, 16'h3001, 0, 1, 0, 4'h8));
    vecs.push_back(mk(0, 0, 1, 0, 0, 16'h3002, 0, 1, 0, 4'h8));
    vecs.push_back(mk(0, 0, 1, 0, 0, 16'h3003, 0, 1, 0, 4'h8));
    vecs.push_back(mk(0, 0, 1, 0, 0, 16'h3003, 0, 0, 1, 4'h9));
    vecs.push_back(mk(1, 1, 0, 0, 0, 16'h5555, 1, 1, 0, 4'h9));
    vecs.push_back(mk(0, 0, 0, 0, 0, 16'h5555, 0, 1, 0, 4'h9));
    vecs.push_back(mk(0, 0, 1, 0, 0, 16'h5556, 0, 1, 0, 4'h9));
    vecs.push_back(mk(0, 0, 1, 0, 0, 16'h5556, 0, 0, 1, 4'hB));
    // masterClear mid-transfer clears everything; counters restart at zero.
    vecs.push_back(mkld(2'd0, 16'h7000, 16'h0005, 16'h5556, 4'hB));
    vecs.push_back(mk(1, 0, 0, 0, 0, 16'h7000, 1, 1, 0, 4'hB));
    vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 4'h0, 0, 2'd0, 16'h0, 16'h0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 1, 1, 0, 4'h0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 0, 1, 0, 4'h0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 16'h0000, 0, 0, 1, 4'h1));

    // Power-up reset, checked while RESET is still high.
    #1 RESET = 1'b1;
    #2 check_cleared("reset");
    @(posedge CLK);
    @(posedge CLK);
    #1 RESET = 1'b0;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);
    idle_inputs();

    // Asynchronous RESET in XFER after one of four steps.
    apply(mkld(2'd1, 16'h6000, 16'h0003, 16'h0000, 4'h1));
    apply(mk(1, 1, 0, 0, 0, 16'h6000, 1, 1, 0, 4'h1));
    apply(mk(0, 0, 0, 0, 0, 16'h6000, 0, 1, 0, 4'h1));
    apply(mk(0, 0, 1, 0, 0, 16'h6001, 0, 1, 0, 4'h1));
    // Step stays asserted so a missed abort would count or pulse tc.
    #2 RESET = 1'b1;
    #1 check_cleared("async_rst");
    @(posedge CLK);
    #1 check_cleared("rst_hold");
    RESET = 1'b0;
    bus.step = 1'b0;
    // ch1 counters were cleared: address 0, word 0 means the first step is TC.
    apply(mk(1, 1, 0, 0, 0, 16'h0000, 1, 1, 0, 4'h0));
    apply(mk(0, 0, 0, 0, 0, 16'h0000, 0, 1, 0, 4'h0));
    apply(mk(0, 0, 1, 0, 0, 16'h0000, 0, 0, 1, 4'h2));
    idle_inputs();

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
